uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_if.sv | 30 +++
 rtl/uart_tx_queue.sv | 80 ++++++++
 tb/tb_uart_tx_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Bus-side push / controller-side pop bundle for the UART transmit queue.
// Overflow signals exist only when UART_TX_QUEUE_OVF_EN is defined.
interface uart_tx_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  we;
  logic [DATA_WIDTH-1:0] din;
  logic                  re;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
`ifdef UART_TX_QUEUE_OVF_EN
  logic                  overflow_clr;
  logic                  overflow;

  modport master (output we, din, re, overflow_clr,
                  input  dout, empty, full, count, overflow);
  modport slave  (input  we, din, re, overflow_clr,
                  output dout, empty, full, count, overflow);
`else
  modport master (output we, din, re,
                  input  dout, empty, full, count);
  modport slave  (input  we, din, re,
                  output dout, empty, full, count);
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// UART TX character queue: circular FWFT buffer, 1-cycle write-to-read, pop same cycle as re; full drops writes
// unless a pop coincides. Sticky overflow flag only with UART_TX_QUEUE_OVF_EN.
module uart_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Flags come from the count register only, never from we/re.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = bus.re && !w_empty;
  assign w_push  = bus.we && (!w_full || w_pop);

  assign bus.empty = w_empty;
  assign bus.full  = w_full;
  assign bus.count = r_count;
  assign bus.dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVF_EN
  logic r_overflow;
  logic w_ovf_set;

  assign w_ovf_set    = bus.we && w_full && !w_pop;
  assign bus.overflow = r_overflow;

  // Set has priority so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (bus.overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: queue-based reference model checked every negedge plus literal expectations.
module tb_uart_tx_queue;
  localparam int DW = 8;
  localparam int DP = 16;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  uart_tx_queue_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of characters.
  logic [DW-1:0] mq [$];
  bit            m_ovf;
  bit            m_pop_ok;
  bit            m_push_ok;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_pop_ok  = bus.re && (mq.size() > 0);
      m_push_ok = bus.we && ((mq.size() < DP) || m_pop_ok);
`ifdef UART_TX_QUEUE_OVF_EN
      if (bus.we && mq.size() == DP && !m_pop_ok) m_ovf = 1'b1;
      else if (bus.overflow_clr)                  m_ovf = 1'b0;
`endif
      if (m_pop_ok)  void'(mq.pop_front());
      if (m_push_ok) mq.push_back(bus.din);
    end
  end

  always @(negedge clk) begin
    chk("model_count", 32'(bus.count), 32'(mq.size()));
    chk("model_empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("model_full",  32'(bus.full),  32'(mq.size() == DP));
    if (mq.size() > 0) chk("model_dout", 32'(bus.dout), 32'(mq[0]));
`ifdef UART_TX_QUEUE_OVF_EN
    chk("model_ovf", 32'(bus.overflow), 32'(m_ovf));
`endif
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bus.we  = w;
    bus.din = d;
    bus.re  = r;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    bus.we  = 1'b0;
    bus.re  = 1'b0;
    bus.din = '0;
`ifdef UART_TX_QUEUE_OVF_EN
    bus.overflow_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three pushes then three pops in order.
    step(1'b1, 8'h41, 1'b0);
    chk("s1_empty_after_push", 32'(bus.empty), 0);
    chk("s1_dout_first", 32'(bus.dout), 32'h41);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    chk("s1_count3", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("s1_pop_data", 32'(bus.dout), 32'h41 + i);
      step(1'b0, 8'h00, 1'b1);
    end
    chk("s1_empty_end", 32'(bus.empty), 1);

    // Fill to full, then a dropped write.
    for (int i = 0; i < DP; i++) step(1'b1, 8'(i), 1'b0);
    chk("s2_full", 32'(bus.full), 1);
    chk("s2_count16", 32'(bus.count), 16);
    step(1'b1, 8'hFF, 1'b0);
    chk("s2_count_after_drop", 32'(bus.count), 16);
    chk("s2_head_after_drop", 32'(bus.dout), 32'h00);
`ifdef UART_TX_QUEUE_OVF_EN
    chk("s2_ovf_set", 32'(bus.overflow), 1);
    bus.overflow_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("s2_ovf_clr", 32'(bus.overflow), 0);
    step(1'b1, 8'hFE, 1'b0);
    chk("s2_ovf_set_wins", 32'(bus.overflow), 1);
    step(1'b0, 8'h00, 1'b0);
    bus.overflow_clr = 1'b0;
    chk("s2_ovf_clr2", 32'(bus.overflow), 0);
`endif

    // Push with pop while full, then drain.
    step(1'b1, 8'hAA, 1'b1);
    chk("s3_count16", 32'(bus.count), 16);
    for (int i = 0; i < DP; i++) begin
      chk("s3_drain", 32'(bus.dout), (i < 15) ? 32'(i + 1) : 32'hAA);
      step(1'b0, 8'h00, 1'b1);
    end
    chk("s3_empty", 32'(bus.empty), 1);

    // Pops on an empty queue.
    step(1'b0, 8'h00, 1'b1);
    chk("s4_re_empty_count", 32'(bus.count), 0);
    chk("s4_re_empty_empty", 32'(bus.empty), 1);
    step(1'b1, 8'h55, 1'b1);
    chk("s4_push_only_count", 32'(bus.count), 1);
    chk("s4_push_only_dout", 32'(bus.dout), 32'h55);
    step(1'b0, 8'h00, 1'b1);

    // Interleaved traffic to wrap both pointers several times.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("s5_pair_dout", 32'(bus.dout), 32'h20 + k);
      step(1'b1, 8'(8'h23 + k), 1'b1);
      chk("s5_pair_count", 32'(bus.count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      chk("s5_tail", 32'(bus.dout), 32'h48 + i);
      step(1'b0, 8'h00, 1'b1);
    end
    chk("s5_empty", 32'(bus.empty), 1);

    // Overflow set, leave 5 queued, then asynchronous reset.
    for (int i = 0; i < DP; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1);
    chk("s6_count5", 32'(bus.count), 5);
    chk("s6_head", 32'(bus.dout), 32'h8B);
`ifdef UART_TX_QUEUE_OVF_EN
    chk("s6_ovf_sticky", 32'(bus.overflow), 1);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_async_empty", 32'(bus.empty), 1);
    chk("s6_async_count", 32'(bus.count), 0);
`ifdef UART_TX_QUEUE_OVF_EN
    chk("s6_async_ovf", 32'(bus.overflow), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    chk("s6_first_push_count", 32'(bus.count), 1);
    chk("s6_first_push_dout", 32'(bus.dout), 32'h77);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
